grant_dispatch: RTL and testbench
=================================

GRANT_DISPATCH -- requirements
Module: grant_dispatch

Interface
REQ-001 Parameter DATA_W, default 8: payload width per requester.
REQ-002 Parameter DEPTH, default 2: output FIFO entries; power of two, at least 2.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 grant  input  4  one-hot grant from the round-robin arbiter; 0000 means no grant.
REQ-006 req_data  input  4*DATA_W  requester payloads; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-007 ack  output  4  registered one-cycle pulse to the requester whose payload was captured.
REQ-008 out_valid  output  1  FIFO head valid.
REQ-009 out_ready  input  1  downstream accepts the head when out_valid and out_ready are both high.
REQ-010 out_data  output  DATA_W  FIFO head payload.
REQ-011 out_src  output  2  FIFO head requester index, 0 to 3.
REQ-012 grant_err  output  1  registered one-cycle pulse when grant has more than one bit set.

Function
REQ-013 FSM states: IDLE and WAIT_REL.
- IDLE: capture when grant is one-hot and the FIFO is not full, or the FIFO is full and a pop occurs in the same cycle; then go to WAIT_REL.
- Otherwise remain in IDLE.
REQ-014 Capture:
- Push {index of grant bit, selected req_data slice} into the FIFO.
- Store grant in cap_grant.
- Drive ack = grant on the following cycle only.
REQ-015 WAIT_REL: no capture; return to IDLE in the cycle grant != cap_grant (including 0000); that grant value is evaluated for capture on the next cycle, not the same cycle.
REQ-016 Requester contract (bench-enforced, not checked by RTL): after seeing ack, the requester deasserts its req for at least one cycle.
REQ-017 grant with 2 or more bits set: no capture, no state change, grant_err pulses next cycle.
REQ-018 FIFO:
- Pop when out_valid && out_ready.
- Simultaneous push and pop is legal at any occupancy, including full and empty.
- Occupancy is unchanged by a simultaneous push and pop.
REQ-019 Empty FIFO: out_valid = 0; out_data and out_src hold their last value and are don't-care.
REQ-020 Pointers are log2(DEPTH) bits and wrap modulo DEPTH; a count register of log2(DEPTH)+1 bits distinguishes full from empty.
REQ-021 Capture-to-out_valid latency is 1 cycle when the FIFO was empty; no combinational path from grant or req_data to out_*.
REQ-022 FIFO full in IDLE with no pop: hold the grant uncaptured (no ack), capture on the first cycle with space.
REQ-023 Payload order at the output equals capture order; no payload is dropped or duplicated.

Reset
REQ-024 rst low asynchronously forces the following, regardless of clk:
- state = IDLE, count = 0, pointers = 0, cap_grant = 0000.
- ack = 0000, grant_err = 0, out_valid = 0, out_data = 0, out_src = 0.
REQ-025 Reset mid-transfer discards FIFO contents and any pending ack.
REQ-026 The first capture is possible on the first rising edge after rst is released.

Structure
REQ-027 The shared package holds:
- The FSM state typedef (IDLE, WAIT_REL).
- The requester count constant NREQ = 4.
- The function converting one-hot to index and flagging multi-hot.
REQ-028 The FIFO is one sub-module, sync_fifo (DATA_W+2 wide, DEPTH deep); grant_dispatch holds the FSM, capture mux and ack/err registers.

Verification
REQ-029 grant=0100, req_data slice 2=0xA5, out_ready=1 -> ack=0100 for one cycle; next cycle out_valid=1, out_data=0xA5, out_src=2; no second capture until grant changes.
REQ-030 out_ready=0, grants 0001 (0x11), 0010 (0x22), 0100 (0x33) in sequence -> first two acked, third held without ack; raise out_ready -> outputs 0x11, 0x22, 0x33 in order, third acked one cycle after its capture.
REQ-031 FIFO full with out_ready=1 and a new grant in the same cycle -> pop and push together, count stays 2, ack issued.
REQ-032 grant=0110 -> grant_err pulses once, no ack, FIFO unchanged.
REQ-033 Assert rst mid-cycle with 2 entries queued -> out_valid=0 and ack=0000 immediately, before any clock edge; after release, grant=1000 with data 0x5A -> normal capture with out_src=3.
REQ-034 grant held at 0001 for 5 cycles, then 0000, then 0001 (new data 0x77) -> exactly two captures and two ack pulses.

Source files
------------

// File: rtl/grant_dispatch_pkg.sv
// Shared types and helpers for the grant dispatcher: FSM state encoding,
// requester count and one-hot grant decoding.
package grant_dispatch_pkg;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned ONE_W = 3;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_REL = 1'b1
  } state_t;

  typedef struct packed {
    logic             one_hot;
    logic             multi_hot;
    logic [IDX_W-1:0] idx;
  } grant_dec_t;

  // Population count of the grant vector; idx is only meaningful when one_hot.
  function automatic grant_dec_t decode_grant(input logic [NREQ-1:0] g);
    grant_dec_t       d;
    logic [ONE_W-1:0] ones;
    d    = '0;
    ones = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (g[i]) begin
        ones  = ones + ONE_W'(1);
        d.idx = IDX_W'(i);
      end
    end
    d.one_hot   = (ones == ONE_W'(1));
    d.multi_hot = (ones > ONE_W'(1));
    return d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head (valid/data), so the consumer
// side never sees a combinational path from the push inputs.
module sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             push_ok_c,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_valid;
  logic [WIDTH-1:0] r_head;

  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic [PTR_W-1:0] w_wr_next;
  logic [PTR_W-1:0] w_rd_next;
  logic [CNT_W-1:0] w_count_next;
  logic [WIDTH-1:0] w_head_next;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_pop     = r_valid && pop_ready;
  assign push_ok_c = !w_full || w_pop;
  assign w_push    = push && push_ok_c;

  // Next pointer/count values; the head register is loaded from the next
  // read slot, bypassing the memory when that slot is being written now.
  always_comb begin
    w_wr_next    = w_push ? (r_wr_ptr + PTR_W'(1)) : r_wr_ptr;
    w_rd_next    = w_pop ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - CNT_W'(1);
    end
    w_head_next = r_head;
    if (w_count_next != '0) begin
      if (w_push && (r_wr_ptr == w_rd_next)) begin
        w_head_next = push_data;
      end else begin
        w_head_next = r_mem[w_rd_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_head   <= '0;
    end else begin
      r_wr_ptr <= w_wr_next;
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      r_valid  <= (w_count_next != '0);
      r_head   <= w_head_next;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_head;

endmodule

// File: rtl/grant_dispatch.sv
// Captures the payload of a one-hot granted requester into an output FIFO,
// acks the requester, and waits for the grant to move before capturing again.
module grant_dispatch
  import grant_dispatch_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        grant,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        ack,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [IDX_W-1:0]       out_src,
  output logic                   grant_err
);

  localparam int unsigned ENTRY_W = DATA_W + IDX_W;

  state_t             r_state;
  state_t             w_state_next;
  logic [NREQ-1:0]    r_cap_grant;
  logic [NREQ-1:0]    r_ack;
  logic               r_err;

  grant_dec_t         w_dec;
  logic               w_capture;
  logic               w_push_ok;
  logic [DATA_W-1:0]  w_sel_data;
  logic [ENTRY_W-1:0] w_push_entry;
  logic [ENTRY_W-1:0] w_head_entry;

  assign w_dec = decode_grant(grant);

  // Payload mux selected by the decoded grant index.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_dec.idx == IDX_W'(i)) begin
        w_sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_push_entry = {w_dec.idx, w_sel_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A multi-hot grant freezes the FSM; in WAIT_REL any other grant change
  // releases to IDLE, which then evaluates the grant on the following cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_dec.one_hot && w_push_ok) begin
          w_state_next = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!w_dec.multi_hot && (grant != r_cap_grant)) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_capture = 1'b0;
    if ((r_state == IDLE) && w_dec.one_hot && w_push_ok) begin
      w_capture = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cap_grant <= '0;
      r_ack       <= '0;
      r_err       <= 1'b0;
    end else begin
      r_ack <= w_capture ? grant : '0;
      r_err <= w_dec.multi_hot;
      if (w_capture) begin
        r_cap_grant <= grant;
      end
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_capture),
    .push_data (w_push_entry),
    .pop_ready (out_ready),
    .push_ok_c (w_push_ok),
    .out_valid (out_valid),
    .out_data  (w_head_entry)
  );

  assign ack       = r_ack;
  assign grant_err = r_err;
  assign out_data  = w_head_entry[DATA_W-1:0];
  assign out_src   = w_head_entry[DATA_W +: IDX_W];

endmodule

// File: tb/tb_grant_dispatch.sv
// Directed bench for grant_dispatch: capture, backpressure, full-FIFO
// push/pop, multi-hot error, async reset and grant-hold behaviour.
module tb_grant_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  grant;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic        grant_err;

  int checks   = 0;
  int failures = 0;
  int ack_cnt  = 0;

  always #5 clk = ~clk;

  grant_dispatch #(
    .DATA_W (8),
    .DEPTH  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .grant     (grant),
    .req_data  (req_data),
    .ack       (ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .grant_err (grant_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] g, input int idx, input logic [7:0] d);
    grant = g;
    req_data[idx*8 +: 8] = d;
  endtask

  initial begin
    rst       = 1'b0;
    grant     = 4'b0000;
    req_data  = '0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_err", 32'(grant_err), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_src", 32'(out_src), 32'h0);
    rst = 1'b1;

    // Single capture with ready downstream
    out_ready = 1'b1;
    drive(4'b0100, 2, 8'hA5);
    step();
    chk("t029_ack", 32'(ack), 32'h4);
    chk("t029_valid", 32'(out_valid), 32'h1);
    chk("t029_data", 32'(out_data), 32'hA5);
    chk("t029_src", 32'(out_src), 32'h2);
    step();
    chk("t029_ack_pulse", 32'(ack), 32'h0);
    chk("t029_popped", 32'(out_valid), 32'h0);
    step();
    chk("t029_no_recap_ack", 32'(ack), 32'h0);
    chk("t029_no_recap_valid", 32'(out_valid), 32'h0);
    grant = 4'b0000;
    step();

    // Backpressure: third grant held while FIFO is full
    out_ready = 1'b0;
    drive(4'b0001, 0, 8'h11);
    step();
    chk("t030_ack0", 32'(ack), 32'h1);
    chk("t030_head11", 32'(out_data), 32'h11);
    grant = 4'b0000;
    step();
    drive(4'b0010, 1, 8'h22);
    step();
    chk("t030_ack1", 32'(ack), 32'h2);
    grant = 4'b0000;
    step();
    drive(4'b0100, 2, 8'h33);
    step();
    chk("t030_held_ack_a", 32'(ack), 32'h0);
    step();
    chk("t030_held_ack_b", 32'(ack), 32'h0);
    chk("t030_head_still11", 32'(out_data), 32'h11);
    out_ready = 1'b1;
    step();
    chk("t030_ack2", 32'(ack), 32'h4);
    chk("t030_head22", 32'(out_data), 32'h22);
    chk("t030_src1", 32'(out_src), 32'h1);
    grant = 4'b0000;
    step();
    chk("t030_head33", 32'(out_data), 32'h33);
    chk("t030_valid33", 32'(out_valid), 32'h1);
    step();
    chk("t030_drained", 32'(out_valid), 32'h0);

    // Full FIFO with simultaneous pop and push
    out_ready = 1'b0;
    drive(4'b1000, 3, 8'h44);
    step();
    grant = 4'b0000;
    step();
    drive(4'b0001, 0, 8'h55);
    step();
    grant = 4'b0000;
    step();
    out_ready = 1'b1;
    drive(4'b0010, 1, 8'h66);
    step();
    chk("t031_ack", 32'(ack), 32'h2);
    chk("t031_head55", 32'(out_data), 32'h55);
    out_ready = 1'b0;
    grant = 4'b0000;
    step();
    chk("t031_hold55", 32'(out_data), 32'h55);
    drive(4'b0100, 2, 8'h99);
    step();
    chk("t031_still_full", 32'(ack), 32'h0);
    grant = 4'b0000;
    out_ready = 1'b1;
    step();
    chk("t031_head66", 32'(out_data), 32'h66);
    chk("t031_valid66", 32'(out_valid), 32'h1);
    step();
    chk("t031_drained", 32'(out_valid), 32'h0);

    // Multi-hot grant
    out_ready = 1'b0;
    drive(4'b0110, 1, 8'hEE);
    step();
    chk("t032_err", 32'(grant_err), 32'h1);
    chk("t032_ack", 32'(ack), 32'h0);
    chk("t032_valid", 32'(out_valid), 32'h0);
    grant = 4'b0000;
    step();
    chk("t032_err_pulse", 32'(grant_err), 32'h0);
    chk("t032_valid_after", 32'(out_valid), 32'h0);

    // Asynchronous reset with two entries queued and an ack pending
    drive(4'b1000, 3, 8'hC1);
    step();
    grant = 4'b0000;
    step();
    drive(4'b0001, 0, 8'hC2);
    step();
    chk("t033_pre_ack", 32'(ack), 32'h1);
    chk("t033_pre_valid", 32'(out_valid), 32'h1);
    #2;
    rst   = 1'b0;
    grant = 4'b0000;
    #1;
    chk("t033_async_valid", 32'(out_valid), 32'h0);
    chk("t033_async_ack", 32'(ack), 32'h0);
    chk("t033_async_data", 32'(out_data), 32'h0);
    step();
    rst = 1'b1;
    drive(4'b1000, 3, 8'h5A);
    step();
    chk("t033_post_ack", 32'(ack), 32'h8);
    chk("t033_post_valid", 32'(out_valid), 32'h1);
    chk("t033_post_data", 32'(out_data), 32'h5A);
    chk("t033_post_src", 32'(out_src), 32'h3);
    grant = 4'b0000;
    out_ready = 1'b1;
    step();
    chk("t033_post_drain", 32'(out_valid), 32'h0);

    // Grant held for several cycles, released, then re-asserted
    ack_cnt = 0;
    drive(4'b0001, 0, 8'h33);
    for (int i = 0; i < 5; i++) begin
      step();
      if (ack != 4'b0000) ack_cnt++;
    end
    grant = 4'b0000;
    step();
    if (ack != 4'b0000) ack_cnt++;
    drive(4'b0001, 0, 8'h77);
    step();
    if (ack != 4'b0000) ack_cnt++;
    chk("t034_data77", 32'(out_data), 32'h77);
    grant = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      step();
      if (ack != 4'b0000) ack_cnt++;
    end
    chk("t034_acks", 32'(ack_cnt), 32'd2);
    chk("t034_drained", 32'(out_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
